// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator, offset-binary in and out.
// Integrators run per input strobe; combs run serially, one per clock.
module cic_decimator #(
  parameter int WIDTH      = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int STAGES     = 3,
  parameter int RATE       = 8,
  parameter int DIFF_DELAY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     x_in,
  output logic [OUT_WIDTH-1:0] y_out,
  output logic                 out_valid,
  output logic                 overrun
);

  localparam int IW = WIDTH + STAGES * $clog2(RATE * DIFF_DELAY);
  localparam int CW = $clog2(RATE);
  localparam int SW = $clog2(STAGES + 1);

  typedef logic signed [IW-1:0] acc_t;
  typedef enum logic [1:0] {IDLE, COMB, LOAD} state_t;

  state_t state, state_nxt;

  acc_t integ     [STAGES];
  acc_t integ_nxt [STAGES];
  acc_t dly       [STAGES][DIFF_DELAY];

  acc_t snap, cval, comb_in, comb_out, s;
  logic signed [WIDTH-1:0] xs;
  logic [OUT_WIDTH-1:0]    top;
  logic [CW-1:0]           cnt;
  logic [SW-1:0]           idx;
  logic dec, load_snap, do_comb, do_load;

  assign xs  = {~x_in[WIDTH-1], x_in[WIDTH-2:0]};
  assign s   = acc_t'(xs);
  assign dec = in_valid && (cnt == CW'(RATE - 1));

  // stage 0 reads the snapshot, later stages chain on the last comb result
  assign comb_in  = (idx == '0) ? snap : cval;
  assign comb_out = comb_in - dly[idx][DIFF_DELAY-1];
  assign top      = cval[IW-1 -: OUT_WIDTH];

  always_comb begin
    integ_nxt[0] = integ[0] + s;
    for (int k = 1; k < STAGES; k++)
      integ_nxt[k] = integ[k] + integ[k-1];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_snap = 1'b0;
    do_comb   = 1'b0;
    do_load   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dec) begin
          state_nxt = COMB;
          load_snap = 1'b1;
        end
      end
      COMB: begin
        do_comb = 1'b1;
        if (idx == SW'(STAGES - 1)) state_nxt = LOAD;
      end
      LOAD: begin
        do_load   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        integ[k] <= '0;
        for (int j = 0; j < DIFF_DELAY; j++)
          dly[k][j] <= '0;
      end
      snap      <= '0;
      cval      <= '0;
      cnt       <= '0;
      idx       <= '0;
      y_out     <= {1'b1, {(OUT_WIDTH-1){1'b0}}};
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= do_load;
      if (in_valid) begin
        for (int k = 0; k < STAGES; k++)
          integ[k] <= integ_nxt[k];
        cnt <= dec ? '0 : cnt + CW'(1);
      end
      // a busy comb pass keeps running; the new snapshot is lost
      if (dec && state != IDLE) overrun <= 1'b1;
      if (load_snap) begin
        snap <= integ_nxt[STAGES-1];
        idx  <= '0;
      end
      if (do_comb) begin
        cval        <= comb_out;
        dly[idx][0] <= comb_in;
        for (int j = 1; j < DIFF_DELAY; j++)
          dly[idx][j] <= dly[idx][j-1];
        idx <= idx + SW'(1);
      end
      if (do_load)
        y_out <= {~top[OUT_WIDTH-1], top[OUT_WIDTH-2:0]};
    end
  end

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Decimating CIC stage between the waveform generator (offset-binary samples strobed at the generator rate) and the PWM modulator (offset-binary duty word).
- N pipelined integrators run at the input-strobe rate. Every RATE accepted samples, a snapshot is taken and passed through N comb stages, one stage per clock, under a small FSM.
- The result is scaled back to input full-scale and presented to the PWM with a one-cycle valid pulse.

Parameters:
- WIDTH, 8: input sample width, offset-binary unsigned.
- OUT_WIDTH, 8: output sample width, offset-binary unsigned; must be ≤ IW.
- STAGES, 3: number of integrator/comb pairs (N); range 1..6.
- RATE, 8: decimation ratio R; power of two, ≥ 2.
- DIFF_DELAY, 1: comb differential delay M; 1 or 2.
- IW (localparam): WIDTH + STAGES*log2(RATE*DIFF_DELAY); internal two's-complement width (17 at defaults).

Ports:
- clock, in, 1: single system clock.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: one-clock strobe; marks x_in as a new sample.
- x_in, in, WIDTH: input sample, offset-binary.
- y_out, out, OUT_WIDTH: decimated sample, offset-binary; held between updates.
- out_valid, out, 1: one-clock pulse when y_out updates.
- overrun, out, 1: sticky; set when a decimation event arrives while the comb FSM is busy.

Behaviour:
- Reset (synchronous, active-high, checked at the clock edge):
  - All integrators, comb delay lines, snapshot, sample counter and FSM clear.
  - FSM goes to IDLE.
  - y_out = 2^(OUT_WIDTH-1) (mid-scale, 0x80 at defaults); out_valid = 0; overrun = 0.
  - Reset mid-operation aborts any comb pass; no out_valid is issued for it.
- Input conversion: s = x_in with MSB inverted, sign-extended to IW.
- Integrators, updated only on in_valid, all using old register values:
  - I1 <= I1 + s.
  - Ik <= Ik + I(k-1), for k = 2..N.
  - Arithmetic wraps modulo 2^IW; no saturation. Wrap is required for correctness.
- Sample counter: 0..RATE-1, advances on each in_valid, wraps to 0.
  - A decimation event occurs on the clock edge that accepts a sample while the counter = RATE-1.
- FSM states: IDLE, COMB, LOAD.
  - IDLE: on a decimation event at edge t, snapshot <= the updated I_N value; stage index <= 1; go to COMB.
  - COMB: one comb per clock. c_k = v - D_k[M-1], where v is the previous stage result (stage 1 uses the snapshot). Shift D_k. At k = N go to LOAD.
  - LOAD: y_out <= c_N[IW-1 -: OUT_WIDTH] with MSB inverted, i.e. truncation back to offset-binary. Assert out_valid for this one cycle. Return to IDLE.
- Latency: out_valid is high in the cycle following edge t+N+1, i.e. STAGES+2 clocks after the decimating sample is accepted.
- Integrators keep accepting samples while the FSM is busy; the snapshot isolates the comb pass from them.
- Overrun: a decimation event while FSM ≠ IDLE sets overrun, which stays set until reset.
  - That event's snapshot is dropped; the pass in progress completes unchanged.
  - This cannot occur unless in_valid arrives on more than RATE of any STAGES+2 consecutive clocks.
- Gain is (R·M)^N = 2^(IW-WIDTH). With OUT_WIDTH = WIDTH, DC output equals DC input exactly once settled.
- Settling: steady state is reached after N·M decimated outputs have been produced.
- in_valid during reset is ignored.

Test Plan:
- DC mid-scale: x_in = 0x80, in_valid every 4 clocks, 80 samples -> exactly 10 out_valid pulses; y_out = 0x80 throughout; overrun = 0.
- DC positive full-scale: x_in = 0xFF continuous -> y_out = 0xFF from the 4th decimated output onward (N·M = 3 outputs to settle). Also check out_valid occurs exactly 5 clocks after each 8th accepted sample.
- DC negative full-scale: x_in = 0x00 -> settles to y_out = 0x00. Then step to 0x80 -> settles back to 0x80 within 3 outputs; no wrap artefacts.
- Sinusoid from the cosine generator: 8-bit cos at 1 kHz into 200 kHz strobes -> y_out tracks the cosine at 25 kHz, amplitude within ±2 LSB of input peaks, out_valid period = 8 strobes.
- Overrun: in_valid held high every clock with RATE = 2, STAGES = 3 (violates the spacing rule) -> overrun = 1 after the second decimation event, and y_out still pulses with valid data from completed passes.
- Reset mid-pass: assert reset in COMB state -> next edge gives FSM IDLE, y_out = 0x80, out_valid = 0, overrun = 0, and no stale out_valid after reset release.
